// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer
// Sequences one spiking-network inference. It clears the network, then drives
// the captured sample for NUM_STEPS timesteps. Next it scans the class
// accumulators for the largest value, with the lowest index winning a tie.
// The winner is held in DONE until the consumer accepts it.
module snn_inference_sequencer #(
  parameter int NUM_SYNAPSES = 10,
  parameter int WIDTH_P      = 8,
  parameter int NUM_STEPS    = 16,
  parameter int IDX_W        = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH_P-1:0] sample_i,
  input  logic               abort_i,
  output logic               ready_o,
  output logic               net_clear_o,
  output logic               net_en_o,
  output logic [WIDTH_P-1:0] net_data_o,
  output logic [IDX_W-1:0]   acc_sel_o,
  input  logic [WIDTH_P-1:0] acc_data_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IDX_W-1:0]   result_class_o,
  output logic [WIDTH_P-1:0] result_value_o,
  output logic               no_spike_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [7:0]         r_step_cnt;
  logic [WIDTH_P-1:0] r_sample_q;
  logic [WIDTH_P-1:0] r_best_val;
  logic [IDX_W-1:0]   r_best_idx;

  logic               r_ready;
  logic               r_net_clear;
  logic               r_net_en;
  logic [WIDTH_P-1:0] r_net_data;
  logic [IDX_W-1:0]   r_acc_sel;
  logic               r_result_valid;
  logic [IDX_W-1:0]   r_result_class;
  logic [WIDTH_P-1:0] r_result_value;
  logic               r_no_spike;

  logic               w_take;
  logic [WIDTH_P-1:0] w_best_val;
  logic [IDX_W-1:0]   w_best_idx;
  logic               w_to_idle;

  // Running arg-max: a strictly greater raw value replaces the current best
  always_comb begin
    w_take     = 1'b0;
    w_best_val = r_best_val;
    w_best_idx = r_best_idx;
    if (acc_data_i > r_best_val) begin
      w_take     = 1'b1;
      w_best_val = acc_data_i;
      w_best_idx = r_acc_sel;
    end else begin
      w_take     = 1'b0;
      w_best_val = r_best_val;
      w_best_idx = r_best_idx;
    end
  end

  // Return-to-idle decision: abort wins everywhere outside IDLE, then the result handshake
  always_comb begin
    w_to_idle = 1'b0;
    case (r_state)
      S_IDLE:                  w_to_idle = 1'b0;
      S_CLEAR, S_RUN, S_SCAN:  w_to_idle = abort_i;
      S_DONE:                  w_to_idle = abort_i | result_ready_i;
      default:                 w_to_idle = 1'b1;
    endcase
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_step_cnt     <= 8'd0;
      r_sample_q     <= '0;
      r_best_val     <= '0;
      r_best_idx     <= '0;
      r_ready        <= 1'b1;
      r_net_clear    <= 1'b0;
      r_net_en       <= 1'b0;
      r_net_data     <= '0;
      r_acc_sel      <= '0;
      r_result_valid <= 1'b0;
      r_result_class <= '0;
      r_result_value <= '0;
      r_no_spike     <= 1'b0;
    end else if (w_to_idle) begin
      r_state        <= S_IDLE;
      r_step_cnt     <= 8'd0;
      r_ready        <= 1'b1;
      r_net_clear    <= 1'b0;
      r_net_en       <= 1'b0;
      r_net_data     <= '0;
      r_acc_sel      <= '0;
      r_result_valid <= 1'b0;
      r_result_class <= '0;
      r_result_value <= '0;
      r_no_spike     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            r_sample_q  <= sample_i;
            r_state     <= S_CLEAR;
            r_ready     <= 1'b0;
            r_net_clear <= 1'b1;
          end else begin
            r_ready     <= 1'b1;
            r_net_clear <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_state     <= S_RUN;
          r_step_cnt  <= 8'd0;
          r_net_clear <= 1'b0;
          r_net_en    <= 1'b1;
          r_net_data  <= r_sample_q;
        end
        S_RUN: begin
          if (r_step_cnt == 8'(NUM_STEPS - 1)) begin
            r_state    <= S_SCAN;
            r_step_cnt <= 8'd0;
            r_net_en   <= 1'b0;
            r_net_data <= '0;
            r_acc_sel  <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
          end else begin
            r_step_cnt <= r_step_cnt + 8'd1;
          end
        end
        S_SCAN: begin
          r_best_val <= w_best_val;
          r_best_idx <= w_best_idx;
          if (r_acc_sel == IDX_W'(NUM_SYNAPSES - 1)) begin
            // Last compare is folded straight into the presented result
            r_state        <= S_DONE;
            r_acc_sel      <= '0;
            r_result_valid <= 1'b1;
            r_result_class <= w_best_idx;
            r_result_value <= w_best_val;
            r_no_spike     <= (w_best_val == '0);
          end else begin
            r_acc_sel <= r_acc_sel + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_result_valid <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o        = r_ready;
  assign net_clear_o    = r_net_clear;
  assign net_en_o       = r_net_en;
  assign net_data_o     = r_net_data;
  assign acc_sel_o      = r_acc_sel;
  assign result_valid_o = r_result_valid;
  assign result_class_o = r_result_class;
  assign result_value_o = r_result_value;
  assign no_spike_o     = r_no_spike;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed self-checking bench for snn_inference_sequencer.
// The accumulator bank is modelled as a table that is indexed by acc_sel_o.
module tb_snn_inference_sequencer;

  localparam int NS = 10;
  localparam int W  = 8;
  localparam int ST = 16;
  localparam int IW = 4;
  localparam int LAT = ST + NS + 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [W-1:0]  sample_i = 8'd0;
  logic          abort_i = 1'b0;
  logic          ready_o, net_clear_o, net_en_o, result_valid_o, no_spike_o;
  logic [W-1:0]  net_data_o, result_value_o, acc_data_i;
  logic [IW-1:0] acc_sel_o, result_class_o;
  logic          result_ready_i = 1'b0;

  logic [W-1:0]  acc_tbl [0:15];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            lat;
  logic [IW-1:0] hold_cls;
  logic [W-1:0]  hold_val;

  assign acc_data_i = acc_tbl[acc_sel_o];

  snn_inference_sequencer #(
    .NUM_SYNAPSES(NS), .WIDTH_P(W), .NUM_STEPS(ST), .IDX_W(IW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .sample_i(sample_i),
    .abort_i(abort_i), .ready_o(ready_o), .net_clear_o(net_clear_o),
    .net_en_o(net_en_o), .net_data_o(net_data_o), .acc_sel_o(acc_sel_o),
    .acc_data_i(acc_data_i), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .result_class_o(result_class_o),
    .result_value_o(result_value_o), .no_spike_o(no_spike_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one inference from acceptance to DONE and checks the network-side behaviour.
  // The returned latency counts the accepting edge as edge 1.
  task automatic run_inf(input logic [W-1:0] samp, input bit hold_start, output int lat_o);
    int n, n_clr, n_en, bad;
    logic [31:0] exp_sel;
    sample_i = samp;
    start_i  = 1'b1;
    step();
    chk("accept_ready", ready_o, 0);
    n = 0; n_clr = int'(net_clear_o); n_en = int'(net_en_o); bad = 0;
    if (!hold_start) start_i = 1'b0;
    sample_i = ~samp;
    while (!result_valid_o && n < 200) begin
      step();
      n++;
      sample_i = ~sample_i;
      n_clr += int'(net_clear_o);
      n_en  += int'(net_en_o);
      if (net_en_o ? (net_data_o !== samp) : (net_data_o !== 8'd0)) bad++;
      exp_sel = (n >= ST + 1 && n <= ST + NS) ? 32'(n - ST - 1) : 32'd0;
      if (32'(acc_sel_o) !== exp_sel) bad++;
    end
    lat_o = n + 1;
    chk("clear_pulses", n_clr, 1);
    chk("en_cycles", n_en, ST);
    chk("data_sel_errors", bad, 0);
  endtask

  task automatic handshake();
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    chk("hs_ready", ready_o, 1);
    chk("hs_valid", result_valid_o, 0);
    chk("hs_class_zero", result_class_o, 0);
    chk("hs_value_zero", result_value_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) acc_tbl[i] = 8'd0;

    // Reset values
    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_outs", {net_clear_o, net_en_o, net_data_o, acc_sel_o, result_valid_o,
                     result_class_o, result_value_o, no_spike_o}, 0);

    // Nominal: first start taken on first edge after reset release
    acc_tbl[0] = 8'd5; acc_tbl[1] = 8'd9; acc_tbl[2] = 8'd200; acc_tbl[3] = 8'd3;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_inf(8'h40, 1'b0, lat);
    chk("nom_latency", lat, LAT);
    chk("nom_class", result_class_o, 2);
    chk("nom_value", result_value_o, 200);
    chk("nom_nospike", no_spike_o, 0);

    // Backpressure: result held stable for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", result_valid_o, 1);
      chk("bp_ready", ready_o, 0);
      chk("bp_stable", {result_class_o, result_value_o}, {4'd2, 8'd200});
    end
    handshake();

    // Tie: lowest index wins
    for (int i = 0; i < NS; i++) acc_tbl[i] = 8'd7;
    run_inf(8'h11, 1'b0, lat);
    chk("tie_class", result_class_o, 0);
    chk("tie_value", result_value_o, 7);
    chk("tie_nospike", no_spike_o, 0);
    handshake();

    // All zero
    for (int i = 0; i < NS; i++) acc_tbl[i] = 8'd0;
    run_inf(8'h22, 1'b0, lat);
    chk("zero_class", result_class_o, 0);
    chk("zero_value", result_value_o, 0);
    chk("zero_nospike", no_spike_o, 1);
    handshake();

    // Winner at the last index
    for (int i = 0; i < NS; i++) acc_tbl[i] = 8'(i + 1);
    run_inf(8'h33, 1'b0, lat);
    chk("last_class", result_class_o, 9);
    chk("last_value", result_value_o, 10);
    handshake();

    // Unsigned compare: 255 beats 128
    for (int i = 0; i < NS; i++) acc_tbl[i] = 8'd128;
    acc_tbl[5] = 8'd255;
    run_inf(8'h80, 1'b0, lat);
    chk("uns_class", result_class_o, 5);
    chk("uns_value", result_value_o, 255);
    handshake();

    // Abort at RUN step 5: the accepting edge enters CLEAR, and step 5 follows six edges later
    sample_i = 8'h55; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("abort_pre_en", net_en_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_ready", ready_o, 1);
    chk("abort_en", net_en_o, 0);
    chk("abort_data", net_data_o, 0);
    begin
      int vcnt;
      vcnt = 0;
      for (int i = 0; i < 30; i++) begin
        step();
        vcnt += int'(result_valid_o);
      end
      chk("abort_no_valid", vcnt, 0);
    end
    sample_i = 8'h66; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("abort_fresh_clear", net_clear_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort2_ready", ready_o, 1);

    // Asynchronous reset in the middle of SCAN
    sample_i = 8'h77; start_i = 1'b1;
    step();
    start_i = 1'b0;
    begin
      int k;
      k = 0;
      while (acc_sel_o != 4'd4 && k < 100) begin
        step();
        k++;
      end
      chk("scan_sel4_reached", acc_sel_o, 4);
    end
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1);
    chk("arst_outs", {net_clear_o, net_en_o, net_data_o, acc_sel_o, result_valid_o,
                      result_class_o, result_value_o, no_spike_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < NS; i++) acc_tbl[i] = 8'd0;
    acc_tbl[3] = 8'd42;
    run_inf(8'h0F, 1'b0, lat);
    chk("arst_latency", lat, LAT);
    chk("arst_class", result_class_o, 3);
    chk("arst_value", result_value_o, 42);

    // Start held high with the sample toggling: both are ignored until IDLE
    hold_cls = result_class_o;
    hold_val = result_value_o;
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done_hold_start", {result_valid_o, ready_o, result_class_o, result_value_o},
          {1'b1, 1'b0, hold_cls, hold_val});
    end
    handshake();
    run_inf(8'hA5, 1'b1, lat);
    chk("hold_latency", lat, LAT);
    chk("hold_class", result_class_o, 3);
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    chk("hold_hs_ready", ready_o, 1);
    chk("hold_hs_clear", net_clear_o, 0);
    step();
    chk("hold_reaccept_ready", ready_o, 0);
    chk("hold_reaccept_clear", net_clear_o, 1);
    start_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("final_ready", ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
